// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and the datapath (slave).
// Signal names follow the datapath's own control-line names.
interface multicycle_control_if #(
   parameter int ALUOP_WIDTH = 3,
   parameter int STATE_WIDTH = 4
);
   logic [5:0]             OP;
   logic                   Zero;
   logic                   MemReady;
   logic                   PCWrite;
   logic                   IorD;
   logic                   IRWrite;
   logic                   MemRead;
   logic                   MemWrite;
   logic                   RegDst;
   logic                   MemtoReg;
   logic                   RegWrite;
   logic                   ALUSrcA;
   logic [1:0]             ALUSrcB;
   logic [1:0]             PCSource;
   logic                   Jal;
   logic [ALUOP_WIDTH-1:0] ALUOp;
   logic [STATE_WIDTH-1:0] State;
   logic                   Fault;

   modport master (
      input  OP, Zero, MemReady,
      output PCWrite, IorD, IRWrite, MemRead, MemWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, PCSource, Jal, ALUOp, State, Fault
   );

   modport slave (
      output OP, Zero, MemReady,
      input  PCWrite, IorD, IRWrite, MemRead, MemWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, PCSource, Jal, ALUOp, State, Fault
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-handshake stalls, timeout and sticky fault.
// Optional JAL support is enabled by defining MULTICYCLE_CTRL_JAL_EN.
module multicycle_control #(
   parameter int ALUOP_WIDTH = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int STATE_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   multicycle_control_if.master  io_bus
);
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_EXEC_I = 4'd9,
      S_JUMP   = 4'd10,
`ifdef MULTICYCLE_CTRL_JAL_EN
      S_JAL    = 4'd11,
`endif
      S_FAULT  = 4'd15
   } state_t;

   localparam logic [5:0] OP_R    = 6'h00;
   localparam logic [5:0] OP_J    = 6'h02;
`ifdef MULTICYCLE_CTRL_JAL_EN
   localparam logic [5:0] OP_JAL  = 6'h03;
`endif
   localparam logic [5:0] OP_BEQ  = 6'h04;
   localparam logic [5:0] OP_BNE  = 6'h05;
   localparam logic [5:0] OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI = 6'h0c;
   localparam logic [5:0] OP_ORI  = 6'h0d;
   localparam logic [5:0] OP_LUI  = 6'h0f;
   localparam logic [5:0] OP_LW   = 6'h23;
   localparam logic [5:0] OP_SW   = 6'h2b;
   localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

   state_t     r_state, w_next;
   logic [5:0] r_op;
   logic [7:0] r_wait;
   logic       r_fault;
   logic       w_mem_state, w_timeout;
   logic       w_pcwrite, w_iord, w_irwrite, w_memread, w_memwrite, w_regdst;
   logic       w_memtoreg, w_regwrite, w_alusrca, w_jal;
   logic [1:0] w_alusrcb, w_pcsource;
   logic [2:0] w_aluop;

   function automatic logic [2:0] imm_aluop(input logic [5:0] op);
      case (op)
         OP_ADDI: imm_aluop = 3'b100;
         OP_ORI:  imm_aluop = 3'b101;
         OP_ANDI: imm_aluop = 3'b110;
         OP_LUI:  imm_aluop = 3'b011;
         default: imm_aluop = 3'b000;
      endcase
   endfunction

   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
   assign w_timeout   = (r_wait == TIMEOUT_C);

   // State, latched opcode, memory wait counter and sticky fault.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_FETCH;
         r_op    <= 6'd0;
         r_wait  <= 8'd0;
         r_fault <= 1'b0;
      end else begin
         r_state <= w_next;
         r_fault <= r_fault | (w_next == S_FAULT);
         if (r_state == S_DECODE) begin
            r_op <= io_bus.OP;
         end else begin
            r_op <= r_op;
         end
         if (w_next != r_state) begin
            r_wait <= 8'd0;
         end else if (w_mem_state && !io_bus.MemReady) begin
            r_wait <= r_wait + 8'd1;
         end else begin
            r_wait <= r_wait;
         end
      end
   end

   // Next-state decode; a memory state faults only if the ack is still absent at the limit.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (io_bus.MemReady)  w_next = S_DECODE;
            else if (w_timeout)   w_next = S_FAULT;
            else                  w_next = S_FETCH;
         end
         S_DECODE: begin
            case (io_bus.OP)
               OP_R:                            w_next = S_EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: w_next = S_EXEC_I;
               OP_LW, OP_SW:                    w_next = S_MEMADR;
               OP_BEQ, OP_BNE:                  w_next = S_BRANCH;
               OP_J:                            w_next = S_JUMP;
`ifdef MULTICYCLE_CTRL_JAL_EN
               OP_JAL:                          w_next = S_JAL;
`endif
               default:                         w_next = S_FAULT;
            endcase
         end
         S_MEMADR: w_next = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (io_bus.MemReady)  w_next = S_MEMWB;
            else if (w_timeout)   w_next = S_FAULT;
            else                  w_next = S_MEMRD;
         end
         S_MEMWR: begin
            if (io_bus.MemReady)  w_next = S_FETCH;
            else if (w_timeout)   w_next = S_FAULT;
            else                  w_next = S_MEMWR;
         end
         S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP: w_next = S_FETCH;
         S_EXEC_R, S_EXEC_I:                 w_next = S_ALUWB;
`ifdef MULTICYCLE_CTRL_JAL_EN
         S_JAL:                              w_next = S_FETCH;
`endif
         S_FAULT:                            w_next = S_FAULT;
         default:                            w_next = S_FAULT;
      endcase
   end

   // Moore control decode; PCWrite/IRWrite are additionally qualified by MemReady or Zero.
   always_comb begin
      w_pcwrite  = 1'b0;
      w_iord     = 1'b0;
      w_irwrite  = 1'b0;
      w_memread  = 1'b0;
      w_memwrite = 1'b0;
      w_regdst   = 1'b0;
      w_memtoreg = 1'b0;
      w_regwrite = 1'b0;
      w_alusrca  = 1'b0;
      w_alusrcb  = 2'b00;
      w_pcsource = 2'b00;
      w_aluop    = 3'b000;
      w_jal      = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_memread = 1'b1;
            w_alusrcb = 2'b01;
            w_aluop   = 3'b001;
            w_irwrite = io_bus.MemReady;
            w_pcwrite = io_bus.MemReady;
         end
         S_DECODE: begin
            w_alusrcb = 2'b11;
            w_aluop   = 3'b001;
         end
         S_MEMADR: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
            w_aluop   = 3'b001;
         end
         S_MEMRD: begin
            w_memread = 1'b1;
            w_iord    = 1'b1;
         end
         S_MEMWB: begin
            w_regwrite = 1'b1;
            w_memtoreg = 1'b1;
         end
         S_MEMWR: begin
            w_memwrite = 1'b1;
            w_iord     = 1'b1;
         end
         S_EXEC_R: begin
            w_alusrca = 1'b1;
            w_aluop   = 3'b111;
         end
         S_ALUWB: begin
            w_regwrite = 1'b1;
            w_regdst   = (r_op == OP_R);
         end
         S_EXEC_I: begin
            w_alusrca = 1'b1;
            w_alusrcb = 2'b10;
            w_aluop   = imm_aluop(r_op);
         end
         S_BRANCH: begin
            w_alusrca  = 1'b1;
            w_aluop    = 3'b010;
            w_pcsource = 2'b01;
            w_pcwrite  = ((r_op == OP_BEQ) && io_bus.Zero) || ((r_op == OP_BNE) && !io_bus.Zero);
         end
         S_JUMP: begin
            w_pcwrite  = 1'b1;
            w_pcsource = 2'b10;
         end
`ifdef MULTICYCLE_CTRL_JAL_EN
         S_JAL: begin
            w_jal      = 1'b1;
            w_regwrite = 1'b1;
            w_pcwrite  = 1'b1;
            w_pcsource = 2'b10;
         end
`endif
         default: w_aluop = 3'b000;
      endcase
   end

   // Reset suppresses every write and memory request on the reset cycle itself.
   assign io_bus.PCWrite  = w_pcwrite  & ~i_reset;
   assign io_bus.IRWrite  = w_irwrite  & ~i_reset;
   assign io_bus.MemRead  = w_memread  & ~i_reset;
   assign io_bus.MemWrite = w_memwrite & ~i_reset;
   assign io_bus.RegWrite = w_regwrite & ~i_reset;
   assign io_bus.IorD     = w_iord;
   assign io_bus.RegDst   = w_regdst;
   assign io_bus.MemtoReg = w_memtoreg;
   assign io_bus.ALUSrcA  = w_alusrca;
   assign io_bus.ALUSrcB  = w_alusrcb;
   assign io_bus.PCSource = w_pcsource;
   assign io_bus.ALUOp    = ALUOP_WIDTH'(w_aluop);
   assign io_bus.State    = STATE_WIDTH'(r_state);
   assign io_bus.Fault    = r_fault;
`ifdef MULTICYCLE_CTRL_JAL_EN
   assign io_bus.Jal      = w_jal;
`else
   assign io_bus.Jal      = 1'b0;
   logic w_unused_jal;
   assign w_unused_jal    = w_jal;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle control FSM for the MIPS datapath, the successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, stalling on memory handshakes.
- Sits between the instruction register opcode field and the shared-memory multi-cycle datapath; drives every mux select and write enable.
- Flags illegal opcodes and memory timeouts through a sticky Fault output.

Parameters:
- ALUOP_WIDTH, 3: width of ALUOp; encodings below are zero-extended; must be >= 3.
- MEM_TIMEOUT, 15: maximum wait cycles for MemReady in any memory state before faulting; must be 1..255.
- STATE_WIDTH, 4: width of the State debug output; must be >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- OP  in  6  opcode, IR[31:26]; sampled in DECODE.
- Zero  in  1  ALU zero flag; sampled in BRANCH.
- MemReady  in  1  memory ack for the current MemRead/MemWrite access.
- PCWrite  out  1  PC load enable.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  instruction register load.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- RegDst  out  1  write register select: 1 = rd, 0 = rt.
- MemtoReg  out  1  write data select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B select: 00 = B, 01 = const 4, 10 = imm, 11 = imm<<2.
- PCSource  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- Jal  out  1  JAL link write: selects reg 31 and PC as write data.
- ALUOp  out  ALUOP_WIDTH  ALU operation class.
- State  out  STATE_WIDTH  current state, for debug.
- Fault  out  1  sticky fault flag.

Behaviour:
- Outputs are Moore-decoded from the state register, except PCWrite/IRWrite (qualified by MemReady or Zero as noted).
- While reset=1, all write/request enables are 0. On the next edge: state = FETCH, wait counter = 0, Fault = 0.
- ALUOp encodings: R = 111, LUI = 011, ADDI = 100, ORI = 101, ANDI = 110, LW/SW/PC+4 = 001, BEQ/BNE = 010. Unlisted states drive 000.
- Unlisted outputs are 0 in every state.
- FETCH(0):
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=001, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Advances to DECODE only when MemReady=1.
- DECODE(1):
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=001 (branch target into ALUOut).
  - Next state by OP: 0x00 -> EXEC_R; 0x08/0x0c/0x0d/0x0f -> EXEC_I; 0x23/0x2b -> MEMADR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; all others -> FAULT.
  - The decoded OP is latched into a register for later states.
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=001; LW -> MEMRD, SW -> MEMWR.
- MEMRD(3): MemRead=1, IorD=1; waits for MemReady, then -> MEMWB.
- MEMWB(4): RegWrite=1, MemtoReg=1, RegDst=0; -> FETCH.
- MEMWR(5): MemWrite=1, IorD=1; waits for MemReady, then -> FETCH.
- EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUOp=111; -> ALUWB.
- ALUWB(7): RegWrite=1, MemtoReg=0; RegDst=1 for R-type, 0 for I-type; -> FETCH.
- EXEC_I(9): ALUSrcA=1, ALUSrcB=10, ALUOp per latched opcode; -> ALUWB.
- BRANCH(8):
  - Drives ALUSrcA=1, ALUSrcB=00, ALUOp=010, PCSource=01.
  - PCWrite=(BEQ & Zero) | (BNE & ~Zero); -> FETCH.
- JUMP(10): PCWrite=1, PCSource=10; -> FETCH.
- FAULT(15): all enables 0, Fault=1; holds until reset.
- Wait counter (memory states FETCH/MEMRD/MEMWR):
  - Increments each cycle MemReady=0 and clears on any state change.
  - Reaching MEM_TIMEOUT with MemReady still 0 -> FAULT on the next edge.
  - MemReady=1 on the same cycle the counter reaches MEM_TIMEOUT counts as success; the FSM advances.
- Latency with MemReady tied 1 (cycles): R/I-ALU 4, LW 5, SW 4, BEQ/BNE 3, J 3.
- Reset mid-instruction: the instruction is abandoned and no writes occur on the reset cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_JAL_EN.
- Defined:
  - OP 0x03 in DECODE -> JAL(11).
  - JAL drives Jal=1, RegWrite=1, PCWrite=1, PCSource=10; -> FETCH. Total 3 cycles.
- Undefined:
  - State 11 does not exist, Jal is tied 0, and OP 0x03 -> FAULT.

Test Plan:
- reset=1 for 2 cycles, MemReady=1, OP=0x00 -> State sequence 0,1,6,7,0; RegWrite=1, RegDst=1 only in state 7; ALUOp=111 in state 6.
- OP=0x23, MemReady low 3 cycles in MEMRD -> state 3 held 4 cycles, then 4 with MemtoReg=1, RegWrite=1; total 8 cycles.
- OP=0x04: Zero=1 -> PCWrite=1 in state 8; repeat with Zero=0 -> PCWrite=0; OP=0x05, Zero=0 -> PCWrite=1.
- MEM_TIMEOUT=15, MemReady=0 forever in FETCH -> FAULT after 15 wait cycles, Fault=1 sticky; reset clears it and returns to State=0.
- OP=0x3f -> DECODE -> FAULT, no RegWrite/MemWrite ever asserted; OP=0x03 -> FAULT without macro, or states 0,1,11 with Jal=1 with macro.
- Reset asserted during MEMWR with MemReady=0 -> MemWrite=0 on that cycle, State=0 next cycle, wait counter=0.
